vga_fb_scaler: RTL and testbench

- Parametrised successor to the fixed 320x240 VGA controller. Generates VGA timing from one system clock and scans a 1-bit-per-pixel Hack-format framebuffer out of the data RAM's screen read port.
- Integer pixel replication (SCALE) maps a framebuffer of (H_ACTIVE/SCALE)x(V_ACTIVE/SCALE) onto the display.
- Sits between RAMROM's screen port and the board VGA pins in the Hack top level.

---
 rtl/vga_fb_scaler.sv | 196 +++++++++++++++++++
 tb/tb_vga_fb_scaler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scaler.sv
// VGA timing generator with integer-scaled scan-out of a 1bpp Hack framebuffer.
// Optional double buffering: define VGA_DBLBUF_EN to add the page_sel input.
module vga_fb_scaler #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SCALE       = 2,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned SCREEN_BASE = 0,
    parameter logic [11:0] FG_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef VGA_DBLBUF_EN
    input  logic              page_sel,
`endif
    input  logic [15:0]       screen_in,
    output logic [ADDR_W-1:0] screen_addr,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              frame_start,
    output logic              vblank
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned WORD_PIX = 16 * SCALE;
    localparam int unsigned WPL      = H_ACTIVE / WORD_PIX;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DW       = $clog2(CLK_DIV);
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     hcount_q, hcount_d;
    logic [VW-1:0]     vcount_q, vcount_d;
    logic [ADDR_W-1:0] screen_addr_q, screen_addr_d;
    logic              fetch_pend_q, fetch_pend_d;
    logic [15:0]       prefetch_q, prefetch_d;
    logic [15:0]       word_q, word_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              frame_start_q, frame_start_d;
    logic              vblank_q, vblank_d;
`ifdef VGA_DBLBUF_EN
    localparam int unsigned PAGE_WORDS = WPL * (V_ACTIVE / SCALE);
    logic              page_q, page_d;
`endif

    logic        tick;
    logic [31:0] h_cur, v_cur, h_nxt, v_nxt, line_nxt;
    logic [31:0] fetch_line, fetch_word, base;
    logic        fetch_hit;
    logic        in_active;
    logic [3:0]  bit_idx;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        tick     = (div_q == DIV_LAST);
        div_d    = tick ? '0 : div_q + 1'b1;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    // Fetches are keyed to the period being entered: the last replicated pixel of a word,
    // or the final pixel of a line when the next line is visible.
    always_comb begin
        h_cur      = 32'(hcount_q);
        v_cur      = 32'(vcount_q);
        h_nxt      = 32'(hcount_d);
        v_nxt      = 32'(vcount_d);
        line_nxt   = (v_nxt == V_TOTAL - 1) ? 32'd0 : v_nxt + 32'd1;
        fetch_hit  = 1'b0;
        fetch_line = '0;
        fetch_word = '0;
        if (h_nxt == H_TOTAL - 1) begin
            if (line_nxt < V_ACTIVE) begin
                fetch_hit  = 1'b1;
                fetch_line = line_nxt;
            end
        end else if (h_nxt < H_ACTIVE - 1 && (h_nxt % WORD_PIX) == WORD_PIX - 1 &&
                     v_nxt < V_ACTIVE) begin
            fetch_hit  = 1'b1;
            fetch_line = v_nxt;
            fetch_word = (h_nxt + 32'd1) / WORD_PIX;
        end

`ifdef VGA_DBLBUF_EN
        // Sampled on the tick just before frame_start so the line-0 prefetch already uses it.
        page_d = page_q;
        if (tick && h_nxt == H_TOTAL - 1 && v_nxt == V_TOTAL - 1)
            page_d = page_sel;
        base = SCREEN_BASE + (page_d ? PAGE_WORDS : 0);
`else
        base = SCREEN_BASE;
`endif

        screen_addr_d = screen_addr_q;
        fetch_pend_d  = 1'b0;
        if (tick && fetch_hit) begin
            screen_addr_d = ADDR_W'(base + (fetch_line / SCALE) * WPL + fetch_word);
            fetch_pend_d  = 1'b1;
        end
        prefetch_d = fetch_pend_q ? screen_in : prefetch_q;
        word_d     = word_q;
        if (tick && h_nxt < H_ACTIVE && (h_nxt % WORD_PIX) == 0 && v_nxt < V_ACTIVE)
            word_d = prefetch_q;
    end

    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        rgb_d     = rgb_q;
        in_active = (h_cur < H_ACTIVE) && (v_cur < V_ACTIVE);
        bit_idx   = 4'((h_cur / SCALE) % 16);
        if (tick) begin
            hs_d  = (h_cur >= HS_START && h_cur < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_d  = (v_cur >= VS_START && v_cur < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            rgb_d = !in_active ? 12'h000 : (word_q[bit_idx] ? FG_COLOR : BG_COLOR);
        end
        frame_start_d = (div_q == '0) && (hcount_q == '0) && (vcount_q == '0);
        vblank_d      = (v_cur >= V_ACTIVE);
    end

    // NOTE: non-blocking assignments, so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            screen_addr_q <= ADDR_W'(SCREEN_BASE);
            fetch_pend_q  <= 1'b0;
            prefetch_q    <= '0;
            word_q        <= '0;
            hs_q          <= ~SYNC_ACTIVE;
            vs_q          <= ~SYNC_ACTIVE;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
`ifdef VGA_DBLBUF_EN
            page_q        <= 1'b0;
`endif
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            screen_addr_q <= screen_addr_d;
            fetch_pend_q  <= fetch_pend_d;
            prefetch_q    <= prefetch_d;
            word_q        <= word_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
`ifdef VGA_DBLBUF_EN
            page_q        <= page_d;
`endif
        end
    end

    assign screen_addr           = screen_addr_q;
    assign vga_hs                = hs_q;
    assign vga_vs                = vs_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign frame_start           = frame_start_q;
    assign vblank                = vblank_q;

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Self-checking bench for vga_fb_scaler using a shrunken display so several frames fit.
module tb_vga_fb_scaler;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int SCALE    = 2;
    localparam int BASE     = 100;
    localparam logic [11:0] FG = 12'hA5C;
    localparam logic [11:0] BG = 12'h312;

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 80
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 14
    localparam int WPL        = H_ACTIVE / (16 * SCALE);          // 2
    localparam int FRAME_PIX  = H_TOTAL * V_TOTAL;                // 1120
    localparam int FRAME_CLKS = CLK_DIV * FRAME_PIX;              // 2240

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] screen_in;
    logic [14:0] screen_addr;
    logic        vga_hs, vga_vs, frame_start, vblank;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;
    int edges    = 0;
    logic cmp_en = 1'b0;
    logic log_en = 1'b0;

    vga_fb_scaler #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SCALE(SCALE),
        .ADDR_W(15), .SCREEN_BASE(BASE), .FG_COLOR(FG), .BG_COLOR(BG), .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .screen_in(screen_in), .screen_addr(screen_addr),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .vblank(vblank)
    );

    initial forever #5 clk = ~clk;

    // Read port: data for an address is available within the following clock.
    assign screen_in = mem[screen_addr[7:0]];

    // Clock edges since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edges);
    endtask

    // ---------------- behavioural model (global pixel index since reset) ----------------
    function automatic logic [11:0] exp_rgb(input int q);
        int h, v, sx, sy;
        logic [15:0] w;
        h  = q % H_TOTAL;
        v  = (q / H_TOTAL) % V_TOTAL;
        if (h >= H_ACTIVE || v >= V_ACTIVE) return 12'h000;
        sx = h / SCALE;
        sy = v / SCALE;
        // The first word after reset was never fetched: the word register still holds 0.
        w  = (q < 16 * SCALE) ? 16'h0000 : mem[BASE + sy * WPL + sx / 16];
        return w[sx % 16] ? FG : BG;
    endfunction

    function automatic logic exp_hs(input int q);
        int h;
        h = q % H_TOTAL;
        return !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    endfunction

    function automatic logic exp_vs(input int q);
        int v;
        v = (q / H_TOTAL) % V_TOTAL;
        return !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    // Does entering pixel period p issue a fetch, and of which word?
    function automatic logic fetch_at(input int p, output int addr);
        int h, v, vt;
        h    = p % H_TOTAL;
        v    = (p / H_TOTAL) % V_TOTAL;
        addr = 0;
        if (h == H_TOTAL - 1) begin
            vt = (v + 1) % V_TOTAL;
            if (vt >= V_ACTIVE) return 1'b0;
            addr = BASE + (vt / SCALE) * WPL;
            return 1'b1;
        end
        if (v >= V_ACTIVE || h >= H_ACTIVE - 1 || (h % (16 * SCALE)) != 16 * SCALE - 1)
            return 1'b0;
        addr = BASE + (v / SCALE) * WPL + (h + 1) / (16 * SCALE);
        return 1'b1;
    endfunction

    function automatic int exp_addr(input int k);
        int a;
        for (int p = k / CLK_DIV; p >= 1; p--)
            if (fetch_at(p, a)) return a;
        return BASE;
    endfunction

    // ---------------- per-cycle compare ----------------
    int k, q;
    logic e_hs, e_vs, e_fs, e_vb;
    logic [11:0] e_rgb;
    always @(negedge clk) begin
        if (cmp_en) begin
            k = edges;
            if (k >= CLK_DIV) begin
                q     = k / CLK_DIV - 1;
                e_hs  = exp_hs(q);
                e_vs  = exp_vs(q);
                e_rgb = exp_rgb(q);
            end else begin
                e_hs  = 1'b1;
                e_vs  = 1'b1;
                e_rgb = 12'h000;
            end
            e_fs = (k >= 1) && ((k - 1) % FRAME_CLKS == 0);
            e_vb = (k >= 1) && ((((k - 1) / CLK_DIV) / H_TOTAL) % V_TOTAL >= V_ACTIVE);
            check("screen_addr", 32'(screen_addr), 32'(exp_addr(k)));
            check("hs", 32'(vga_hs), 32'(e_hs));
            check("vs", 32'(vga_vs), 32'(e_vs));
            check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
            check("frame_start", 32'(frame_start), 32'(e_fs));
            check("vblank", 32'(vblank), 32'(e_vb));
        end
    end

    // ---------------- event log for the directed timing checks ----------------
    int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], vb_rise[$], vb_fall[$], fs_rise[$];
    int addr_edge[$], addr_val[$];
    logic p_hs = 1'b1, p_vs = 1'b1, p_vb = 1'b0, p_fs = 1'b0;
    logic [14:0] p_addr = 15'(BASE);
    always @(negedge clk) begin
        if (log_en) begin
            if (p_hs && !vga_hs) hs_fall.push_back(edges);
            if (!p_hs && vga_hs) hs_rise.push_back(edges);
            if (p_vs && !vga_vs) vs_fall.push_back(edges);
            if (!p_vs && vga_vs) vs_rise.push_back(edges);
            if (!p_vb && vblank) vb_rise.push_back(edges);
            if (p_vb && !vblank) vb_fall.push_back(edges);
            if (!p_fs && frame_start) fs_rise.push_back(edges);
            if (screen_addr != p_addr) begin
                addr_edge.push_back(edges);
                addr_val.push_back(32'(screen_addr));
            end
        end
        p_hs   <= vga_hs;
        p_vs   <= vga_vs;
        p_vb   <= vblank;
        p_fs   <= frame_start;
        p_addr <= screen_addr;
    end

    function automatic int qget(input int qq[$], input int i);
        return (i < qq.size()) ? qq[i] : -1;
    endfunction

    int a;
    logic hit;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'((i * 40503) ^ 32'h5A5A);
        mem[BASE]     = 16'h0001;
        mem[BASE + 1] = 16'h8000;

        reset = 1'b1;
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        log_en = 1'b1;

        // Hand-computed pins on the model itself.
        check("pin_rgb_post_reset", 32'(exp_rgb(0)), 32'(BG));
        check("pin_rgb_l0_p0", 32'(exp_rgb(FRAME_PIX + 0)), 32'(FG));
        check("pin_rgb_l0_p1", 32'(exp_rgb(FRAME_PIX + 1)), 32'(FG));
        check("pin_rgb_l0_p2", 32'(exp_rgb(FRAME_PIX + 2)), 32'(BG));
        check("pin_rgb_l0_p31", 32'(exp_rgb(FRAME_PIX + 31)), 32'(BG));
        check("pin_rgb_l0_p62", 32'(exp_rgb(FRAME_PIX + 62)), 32'(FG));
        check("pin_rgb_l0_p63", 32'(exp_rgb(FRAME_PIX + 63)), 32'(FG));
        check("pin_rgb_blank", 32'(exp_rgb(FRAME_PIX + 64)), 32'h000);
        check("pin_rgb_l1_p0", 32'(exp_rgb(FRAME_PIX + 80)), 32'(FG));
        check("pin_rgb_l1_p63", 32'(exp_rgb(FRAME_PIX + 143)), 32'(FG));
        hit = fetch_at(31, a);       check("pin_fetch_l0w1", 32'(a), 32'd101);
        hit = fetch_at(79, a);       check("pin_fetch_l1w0", 32'(a), 32'd100);
        hit = fetch_at(159, a);      check("pin_fetch_l2w0", 32'(a), 32'd102);
        hit = fetch_at(511, a);      check("pin_fetch_l6w1", 32'(a), 32'd107);
        hit = fetch_at(639, a);      check("pin_fetch_vblank", 32'(hit), 32'd0);
        hit = fetch_at(1119, a);     check("pin_fetch_prefetch_l0", 32'(a), 32'd100);

        repeat (3 * FRAME_CLKS) @(posedge clk);
        log_en = 1'b0;

        // Directed timing, in clocks after reset release.
        check("first_frame_start", 32'(qget(fs_rise, 0)), 32'd1);
        check("frame_period", 32'(qget(fs_rise, 1) - qget(fs_rise, 0)), 32'd2240);
        check("frame_start_count", 32'(fs_rise.size()), 32'd3);
        check("hs_first_fall", 32'(qget(hs_fall, 0)), 32'd138);
        check("hs_low_width", 32'(qget(hs_rise, 0) - qget(hs_fall, 0)), 32'd16);
        check("hs_period", 32'(qget(hs_fall, 1) - qget(hs_fall, 0)), 32'd160);
        check("hs_line_count", 32'(hs_fall.size()), 32'd42);
        check("vs_first_fall", 32'(qget(vs_fall, 0)), 32'd1602);
        check("vs_low_width", 32'(qget(vs_rise, 0) - qget(vs_fall, 0)), 32'd320);
        check("vblank_rise", 32'(qget(vb_rise, 0)), 32'd1281);
        check("vblank_width", 32'(qget(vb_fall, 0) - qget(vb_rise, 0)), 32'd960);
        check("addr_first_edge", 32'(qget(addr_edge, 0)), 32'd62);
        check("addr_first_val", 32'(qget(addr_val, 0)), 32'd101);
        check("addr_last_active", 32'(qget(addr_val, 14)), 32'd107);
        check("addr_prefetch_edge", 32'(qget(addr_edge, 15)), 32'd2238);
        check("addr_prefetch_val", 32'(qget(addr_val, 15)), 32'd100);
        check("addr_fetch_count", 32'(addr_val.size()), 32'd48);

        // Mid-frame reset at line 5, pixel 30.
        repeat (CLK_DIV * (5 * H_TOTAL + 30)) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_hs", 32'(vga_hs), 32'd1);
        check("midrst_vs", 32'(vga_vs), 32'd1);
        check("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        check("midrst_addr", 32'(screen_addr), 32'(BASE));
        check("midrst_fs", 32'(frame_start), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (FRAME_CLKS + 400) @(posedge clk);

        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
